// File: rtl/mdu_pkg.sv
// Shared op codes, request bundle and classification for the MDU issue front end.
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {[MDU_MULT:MDU_MSUBU]};
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return (op == MDU_MFHI) || (op == MDU_MFLO);
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        return (op inside {[MDU_MULT:MDU_DIVU]}) ||
               (op inside {[MDU_MADD:MDU_MSUBU]});
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline request/response and MDU issue bus of the MDU issue front end.
interface mdu_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [3:0]    mdu_op;
    logic [31:0]   mdu_a;
    logic [31:0]   mdu_b;
    logic          mdu_busy;
    logic [31:0]   mdu_result;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          err_illegal;
    logic [CW-1:0] pending;
    logic          idle;

    // Master is the pipeline plus MDU side; slave is the issue controller.
    modport master (
        output flush, req_valid, req_op, req_a, req_b,
        output mdu_busy, mdu_result,
        input  req_ready, mdu_op, mdu_a, mdu_b,
        input  rsp_valid, rsp_data, err_illegal, pending, idle
    );

    modport slave (
        input  flush, req_valid, req_op, req_a, req_b,
        input  mdu_busy, mdu_result,
        output req_ready, mdu_op, mdu_a, mdu_b,
        output rsp_valid, rsp_data, err_illegal, pending, idle
    );
endinterface

// File: rtl/mdu_req_fifo.sv
// In-order request queue of {op, a, b} with flush and occupancy count.
module mdu_req_fifo
    import mdu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  mdu_req_t      wdata,
    output mdu_req_t      rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    mdu_req_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue front end: queues MD requests, issues when the MDU is free.
// Define MDU_ISSUE_BYPASS_EN to send a request straight to an idle MDU.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    mdu_issue_ctrl_if.slave bus
);

    mdu_req_t      req;
    mdu_req_t      head;
    mdu_req_t      iss;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic          byp;
    logic          rsp_valid_q;
    logic [31:0]   rsp_data_q;
    logic          err_q;

    assign req    = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
    assign legal  = is_legal(bus.req_op);
    assign accept = bus.req_valid && bus.req_ready;

`ifdef MDU_ISSUE_BYPASS_EN
    // Flush is already excluded through req_ready.
    assign byp = accept && legal && empty && !bus.mdu_busy;
`else
    assign byp = 1'b0;
`endif

    assign pop  = !empty && !bus.mdu_busy && !bus.flush;
    assign push = accept && legal && !byp;

    mdu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .wdata (req),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        iss = '0;
        unique case (1'b1)
            pop:     iss = head;
            byp:     iss = req;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= is_read(iss.op);
            if (is_read(iss.op)) rsp_data_q <= bus.mdu_result;
            err_q       <= accept && !legal;
        end
    end

    assign bus.req_ready   = !full && !bus.flush;
    assign bus.mdu_op      = iss.op;
    assign bus.mdu_a       = iss.a;
    assign bus.mdu_b       = iss.b;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.err_illegal = err_q;
    assign bus.pending     = count;
    assign bus.idle        = empty && !bus.mdu_busy;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl with a behavioural MDU model and issue/read scoreboards.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int DEPTH = 4;
`ifdef MDU_ISSUE_BYPASS_EN
    localparam int ISS = 0;
`else
    localparam int ISS = 1;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] op;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cyc = -1;

    logic [67:0] exp_iss[$];
    logic [31:0] exp_rsp[$];
    ev_t         hist[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_issue_ctrl_if #(.DEPTH(DEPTH)) bus();

    mdu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural MDU: hi/lo registers plus a busy countdown
    logic [31:0] hi;
    logic [31:0] lo;
    int          bcnt = 0;
    logic [63:0] sprod;
    logic [63:0] uprod;

    assign sprod = {{32{bus.mdu_a[31]}}, bus.mdu_a} * {{32{bus.mdu_b[31]}}, bus.mdu_b};
    assign uprod = {32'b0, bus.mdu_a} * {32'b0, bus.mdu_b};
    assign bus.mdu_busy = (bcnt != 0);
    assign bus.mdu_result = (bus.mdu_op == MDU_MFHI) ? hi :
                            (bus.mdu_op == MDU_MFLO) ? lo : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            bcnt <= 0;
        end else begin
            if (bcnt != 0) bcnt <= bcnt - 1;
            case (bus.mdu_op)
                MDU_MULT:  begin {hi, lo} <= sprod; bcnt <= MDU_MULT_LAT; end
                MDU_MULTU: begin {hi, lo} <= uprod; bcnt <= MDU_MULT_LAT; end
                MDU_DIV: begin
                    lo <= $signed(bus.mdu_a) / $signed(bus.mdu_b);
                    hi <= $signed(bus.mdu_a) % $signed(bus.mdu_b);
                    bcnt <= MDU_DIV_LAT;
                end
                MDU_DIVU: begin
                    lo <= bus.mdu_a / bus.mdu_b;
                    hi <= bus.mdu_a % bus.mdu_b;
                    bcnt <= MDU_DIV_LAT;
                end
                MDU_MTHI:  hi <= bus.mdu_a;
                MDU_MTLO:  lo <= bus.mdu_a;
                MDU_MADD:  begin {hi, lo} <= {hi, lo} + sprod; bcnt <= MDU_MULT_LAT; end
                MDU_MADDU: begin {hi, lo} <= {hi, lo} + uprod; bcnt <= MDU_MULT_LAT; end
                MDU_MSUB:  begin {hi, lo} <= {hi, lo} - sprod; bcnt <= MDU_MULT_LAT; end
                MDU_MSUBU: begin {hi, lo} <= {hi, lo} - uprod; bcnt <= MDU_MULT_LAT; end
                default: ;
            endcase
        end
    end

    // Scoreboard monitors, sampled mid-cycle
    always @(negedge clk) begin : mon
        logic [67:0] e;
        logic [31:0] r;
        #1;
        if (!reset) begin
            if (bus.mdu_op != 4'd0) begin
                hist.push_back('{cyc, bus.mdu_op});
                checks++;
                if (exp_iss.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected got op=%0d want none", bus.mdu_op);
                end else begin
                    e = exp_iss.pop_front();
                    if ({bus.mdu_op, bus.mdu_a, bus.mdu_b} !== e) begin
                        errors++;
                        $display("FAIL issue_data got %h want %h",
                                 {bus.mdu_op, bus.mdu_a, bus.mdu_b}, e);
                    end
                end
            end
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got %h want none", bus.rsp_data);
                end else begin
                    r = exp_rsp.pop_front();
                    if (bus.rsp_data !== r) begin
                        errors++;
                        $display("FAIL rsp_data got %h want %h", bus.rsp_data, r);
                    end
                end
            end
        end
    end

    function automatic int hcyc(input int k);
        return (k < hist.size()) ? hist[k].cyc : -1;
    endfunction

    // Called just after a posedge; returns the accept cycle
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rexp, output int t);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL send_timeout ready=0 want 1 op=%0d", op);
        end else begin
            if (is_legal(op)) exp_iss.push_back({op, a, b});
            if (is_read(op)) exp_rsp.push_back(rexp);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (!(bus.idle && exp_iss.size() == 0 && exp_rsp.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout iss_left=%0d rsp_left=%0d want 0",
                     exp_iss.size(), exp_rsp.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_idle got %b%b want 11", bus.req_ready, bus.idle);
        end
        checks++;
        if (bus.pending !== '0 || bus.mdu_op !== '0) begin
            errors++;
            $display("FAIL reset_pending_op got %0d/%0d want 0/0", bus.pending, bus.mdu_op);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got %b %h %b want 0 0 0",
                     bus.rsp_valid, bus.rsp_data, bus.err_illegal);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult_read;
        int t0;
        int t1;
        hist.delete();
        send(MDU_MULT, 32'd3, 32'd4, 32'd0, t0);
        send(MDU_MFLO, 32'd0, 32'd0, 32'd12, t1);
        drain();
        checks++;
        if (hcyc(0) != t0 + ISS) begin
            errors++;
            $display("FAIL mult_issue_cyc got %0d want %0d", hcyc(0) - t0, ISS);
        end
        checks++;
        if (hcyc(1) != t0 + ISS + 6) begin
            errors++;
            $display("FAIL mflo_issue_cyc got %0d want %0d", hcyc(1) - t0, ISS + 6);
        end
        checks++;
        if (rsp_cyc != t0 + ISS + 7) begin
            errors++;
            $display("FAIL mflo_rsp_cyc got %0d want %0d", rsp_cyc - t0, ISS + 7);
        end
    endtask

    task automatic test_div_read;
        int t0;
        int t1;
        hist.delete();
        send(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, t0);
        send(MDU_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFF, t1);
        send(MDU_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFD, t1);
        drain();
        checks++;
        if (hcyc(1) != t0 + ISS + 11 || hcyc(2) != t0 + ISS + 12) begin
            errors++;
            $display("FAIL div_read_cyc got %0d/%0d want %0d/%0d",
                     hcyc(1) - t0, hcyc(2) - t0, ISS + 11, ISS + 12);
        end
    endtask

    task automatic test_back_to_back;
        int t0;
        int t;
        int t5;
        hist.delete();
        send(MDU_DIV, 32'd100, 32'd7, 32'd0, t0);
        for (int i = 1; i <= 4; i++) send(MDU_MTLO, i, 32'd0, 32'd0, t);
        @(negedge clk);
        checks++;
        if (bus.pending !== 3'd4) begin
            errors++;
            $display("FAIL full_pending got %0d want 4", bus.pending);
        end
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", bus.req_ready);
        end
        @(posedge clk);
        #1;
        send(MDU_MFLO, 32'd0, 32'd0, 32'd4, t5);
        drain();
        checks++;
        if (hcyc(1) != t0 + ISS + 11 || t5 != hcyc(1) + 1) begin
            errors++;
            $display("FAIL fifth_accept_cyc got %0d pop %0d want %0d pop %0d",
                     t5 - t0, hcyc(1) - t0, ISS + 12, ISS + 11);
        end
    endtask

    task automatic test_mthi;
        int t0;
        int t1;
        hist.delete();
        send(MDU_MTHI, 32'hA5A5_A5A5, 32'd0, 32'd0, t0);
        send(MDU_MFHI, 32'd0, 32'd0, 32'hA5A5_A5A5, t1);
        drain();
        checks++;
        if (hcyc(0) != t0 + ISS || hcyc(1) != hcyc(0) + 1) begin
            errors++;
            $display("FAIL mthi_mfhi_cyc got %0d/%0d want %0d/%0d",
                     hcyc(0) - t0, hcyc(1) - t0, ISS, ISS + 1);
        end
    endtask

    task automatic test_flush;
        int t0;
        int t;
        int nh;
        int n;
        hist.delete();
        send(MDU_DIV, 32'd9, 32'd2, 32'd0, t0);
        send(MDU_MULT, 32'd1, 32'd1, 32'd0, t);
        send(MDU_MTHI, 32'd5, 32'd0, 32'd0, t);
        send(MDU_MFLO, 32'd0, 32'd0, 32'd0, t);
        nh = hist.size();
        bus.flush = 1'b1;
        exp_iss.delete();
        exp_rsp.delete();
        @(negedge clk);
        checks++;
        if (bus.mdu_op !== '0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle got op=%0d ready=%b want 0 0", bus.mdu_op, bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pending !== '0) begin
            errors++;
            $display("FAIL flush_pending got %0d want 0", bus.pending);
        end
        n = 0;
        while (!bus.idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.idle || hist.size() != nh) begin
            errors++;
            $display("FAIL flush_quiet got idle=%b issues=%0d want 1 %0d",
                     bus.idle, hist.size(), nh);
        end
        @(posedge clk);
        #1;
        send(MDU_MFHI, 32'd0, 32'd0, 32'd1, t);
        send(MDU_MFLO, 32'd0, 32'd0, 32'd4, t);
        drain();
    endtask

    task automatic test_illegal;
        logic [3:0] ops[3];
        int t;
        int pulses;
        ops = '{4'd14, 4'd0, 4'd15};
        for (int k = 0; k < 3; k++) begin
            hist.delete();
            send(ops[k], 32'd1, 32'd2, 32'd0, t);
            @(negedge clk);
            checks++;
            if (bus.err_illegal !== 1'b1 || bus.pending !== '0 || bus.mdu_op !== '0) begin
                errors++;
                $display("FAIL illegal_%0d got err=%b pend=%0d op=%0d want 1 0 0",
                         ops[k], bus.err_illegal, bus.pending, bus.mdu_op);
            end
            pulses = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.err_illegal) pulses++;
            end
            checks++;
            if (pulses != 0 || hist.size() != 0) begin
                errors++;
                $display("FAIL illegal_once_%0d got extra=%0d issues=%0d want 0 0",
                         ops[k], pulses, hist.size());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_madd;
        int t;
        send(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, t);
        send(MDU_MADD, 32'hFFFF_FFFF, 32'd3, 32'd0, t);
        send(MDU_MFHI, 32'd0, 32'd0, 32'h0000_0001, t);
        send(MDU_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFB, t);
        drain();
    endtask

    initial begin
        test_reset();
        test_mult_read();
        test_div_read();
        test_back_to_back();
        test_mthi();
        test_flush();
        test_illegal();
        test_madd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
